dct_odd_stage_cfg: RTL and testbench
====================================

Name: dct_odd_stage_cfg

Overview:
- Parametrised successor to the fixed 32-point odd-part shift-add stage.
- Computes the odd-index outputs of the HEVC forward DCT for 4, 8, 16 or 32 points, selected per beat.
- Adds a valid/ready handshake with global stall, a configurable pipeline depth, and round-and-saturate output scaling.
- Sits between the even/odd input butterfly (b-terms) and the output reorder buffer in the 1-D transform datapath.

Parameters:
- IN_W, 20, signed width of each b input lane.
- OUT_W, 20, signed width of each y output lane.
- PIPE, 5, total latency in cycles, from input accept to output valid; legal range 2..8.
- SHIFT, 0, arithmetic right shift applied with rounding before saturation; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_size  in  2  transform size of the beat: 0=4pt, 1=8pt, 2=16pt, 3=32pt.
- b_flat  in  16*IN_W  lane j (bits j*IN_W +: IN_W) = signed bj; lanes j>=N/2 ignored.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out_size  out  2  in_size carried with the beat.
- y_flat  out  16*OUT_W  lane k = y(2k+1); lanes k>=N/2 driven 0.

Behaviour:
- Function: for N = 4<<in_size and M = N/2, lane k (k<M) = sum over j<M of C_N[2k+1][j]*bj.
  - C_N is the HEVC integer DCT matrix: C_N[r][j] = C_32[r*32/N][j].
  - Signs follow the standard matrix.
  - 4pt rows: (83,36),(36,-83). 8pt row 1: 89,75,50,18. 16pt row 1: 90,87,80,70,57,43,25,9. 32pt row 1: 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
- Arithmetic:
  - All constant products are realised as shift-add networks; no generic multiplier may be inferred.
  - Internal accumulation is IN_W+11 bits signed; no intermediate overflow is permitted.
- Output scaling:
  - If SHIFT>0: acc' = (acc + (1<<(SHIFT-1))) >>> SHIFT. If SHIFT=0: acc' = acc.
  - Saturate acc' to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Pipeline:
  - Stage 1 registers the products; middle stages form the adder tree; the final stage does round/saturate.
  - out_size and the valid bit travel alongside the data.
  - Latency is exactly PIPE cycles when there is no stall.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - A beat is accepted when in_valid & in_ready.
  - During stall every stage register holds its value.
  - No bubble compression: empty stages do not advance during a stall.
  - Unaccepted cycles insert valid=0 bubbles.
- Output stability: while out_valid=1 and out_ready=0, y_flat and out_size are held stable.
- Size changes: in_size may change every beat. Mixed sizes in flight are processed independently, with no flush required.
- Reset:
  - rst clears all valid bits and all data/size registers to 0.
  - Outputs after reset: out_valid=0, y_flat=0, out_size=0, in_ready=1.
  - Reset mid-stream discards in-flight beats; the first valid output after reset comes PIPE cycles after the first post-reset accept.
- Zeroing: lanes k>=M are 0 regardless of the ignored inputs.

Test Plan:
- Impulse, 32pt: SHIFT=0, size=3, b0=1, others 0 (ignored lanes filled with random data) -> after 5 cycles y lanes = 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
- Impulse, 4pt and 8pt:
  - size=0, b0=1 -> y0=83, y1=36, lanes 2..15=0.
  - size=0, b1=1 -> y0=36, y1=-83.
  - size=1, b0=1 -> 89,75,50,18, rest 0.
- Mixed sizes back-to-back: beats of size 3,0,2,1 on consecutive cycles -> four consecutive outputs, each matching a golden model, out_size=3,0,2,1.
- Saturation and rounding:
  - size=3, all bj=524287 -> y0=524287; all bj=-524288 -> y0=-524288.
  - SHIFT=7, b0=1 -> y0=1, y15=0.
  - SHIFT=7, b0=-1 -> y0=-1.
- Backpressure: hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, y_flat stable, no beat lost or duplicated; on release, outputs resume in order.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale beat ever emitted, and a new beat appears exactly PIPE cycles after its accept.

Source files
------------

// File: rtl/dct_odd_stage_cfg_if.sv
// Beat-level handshake bundle between the input butterfly, the odd-part
// stage and the output reorder buffer.
interface dct_odd_stage_cfg_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 20
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_size;
    logic [16*IN_W-1:0]    b_flat;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_size;
    logic [16*OUT_W-1:0]   y_flat;

    modport master (
        output in_valid, in_size, b_flat, out_ready,
        input  in_ready, out_valid, out_size, y_flat
    );

    modport slave (
        input  in_valid, in_size, b_flat, out_ready,
        output in_ready, out_valid, out_size, y_flat
    );
endinterface

// File: rtl/dct_odd_stage_cfg.sv
// Odd-index outputs of the HEVC forward DCT (4/8/16/32 point, chosen per beat),
// shift-add products, stallable pipeline of PIPE stages, round-and-saturate output.
module dct_odd_stage_cfg #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 20,
    parameter int PIPE  = 5,
    parameter int SHIFT = 0
) (
    input logic               clk,
    input logic               rst,
    dct_odd_stage_cfg_if.slave io
);
    localparam int ACC_W = IN_W + 11;
    localparam int RND_I = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef acc_t acc_vec_t [16];

    localparam acc_t Y_MAX = acc_t'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam acc_t Y_MIN = ~Y_MAX;

    // 32-point cosine magnitudes indexed by angle n (pi*n/64), n = 0..32
    localparam int MAG [33] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67,
                                64, 61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

    function automatic int coef(input int size_idx, input int k, input int j);
        int npt;
        int n;
        npt = 4 << size_idx;
        if (k >= npt / 2 || j >= npt / 2) return 0;
        n = ((2 * k + 1) * (32 / npt) * (2 * j + 1)) % 128;
        if (n <= 32) return MAG[n];
        if (n <= 64) return -MAG[64 - n];
        if (n <= 96) return -MAG[n - 64];
        return MAG[128 - n];
    endfunction

    // Coefficients are elaboration constants, so each call folds to a few adders.
    function automatic acc_t shift_add(input logic signed [IN_W-1:0] b, input int c);
        acc_t bx;
        acc_t acc;
        int   a;
        bx  = acc_t'(b);
        acc = '0;
        a   = (c < 0) ? -c : c;
        for (int i = 0; i < 7; i++) begin
            if (a[i]) acc = acc + (bx <<< i);
        end
        return (c < 0) ? -acc : acc;
    endfunction

    function automatic logic signed [OUT_W-1:0] rnd_sat(input acc_t a);
        acc_t r;
        r = (a + acc_t'(RND_I)) >>> SHIFT;
        if (r > Y_MAX)      r = Y_MAX;
        else if (r < Y_MIN) r = Y_MIN;
        return r[OUT_W-1:0];
    endfunction

    logic                      stall;
    logic                      v_d    [PIPE];
    logic                      v_q    [PIPE];
    logic [1:0]                size_d [PIPE];
    logic [1:0]                size_q [PIPE];
    acc_t                      prod_d [16][16];
    acc_t                      prod_q [16][16];
    acc_vec_t                  acc_sum;
    acc_vec_t                  acc_src;
    logic signed [OUT_W-1:0]   y_d    [16];
    logic signed [OUT_W-1:0]   y_q    [16];
    logic [16*OUT_W-1:0]       y_pack;

    assign stall        = v_q[PIPE-1] & ~io.out_ready;
    assign io.in_ready  = ~stall;
    assign io.out_valid = v_q[PIPE-1];
    assign io.out_size  = size_q[PIPE-1];
    assign io.y_flat    = y_pack;

    // Stages only load when a beat moves into them; bubbles leave old data in place.
    always_comb begin : ctl_path
        v_d    = v_q;
        size_d = size_q;
        if (!stall) begin
            v_d[0] = io.in_valid;
            if (io.in_valid) size_d[0] = io.in_size;
            for (int s = 1; s < PIPE; s++) begin
                v_d[s] = v_q[s-1];
                if (v_q[s-1]) size_d[s] = size_q[s-1];
            end
        end
    end

    always_comb begin : products
        prod_d = prod_q;
        if (!stall && io.in_valid) begin
            for (int k = 0; k < 16; k++) begin
                for (int j = 0; j < 16; j++) begin
                    case (io.in_size)
                        2'd0:    prod_d[k][j] = shift_add($signed(io.b_flat[j*IN_W +: IN_W]), coef(0, k, j));
                        2'd1:    prod_d[k][j] = shift_add($signed(io.b_flat[j*IN_W +: IN_W]), coef(1, k, j));
                        2'd2:    prod_d[k][j] = shift_add($signed(io.b_flat[j*IN_W +: IN_W]), coef(2, k, j));
                        default: prod_d[k][j] = shift_add($signed(io.b_flat[j*IN_W +: IN_W]), coef(3, k, j));
                    endcase
                end
            end
        end
    end

    always_comb begin : adder_tree
        for (int k = 0; k < 16; k++) begin
            acc_sum[k] = '0;
            for (int j = 0; j < 16; j++) acc_sum[k] = acc_sum[k] + prod_q[k][j];
        end
    end

    // First middle stage registers the tree; any further stages are retiming slack.
    if (PIPE > 2) begin : g_mid
        acc_vec_t acc_d [PIPE-2];
        acc_vec_t acc_q [PIPE-2];

        always_comb begin
            acc_d = acc_q;
            if (!stall) begin
                if (v_q[0]) acc_d[0] = acc_sum;
                for (int m = 1; m < PIPE - 2; m++) begin
                    if (v_q[m]) acc_d[m] = acc_q[m-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) acc_q <= '{default: '{default: '0}};
            else     acc_q <= acc_d;
        end

        assign acc_src = acc_q[PIPE-3];
    end else begin : g_direct
        assign acc_src = acc_sum;
    end

    always_comb begin : final_stage
        y_d = y_q;
        if (!stall && v_q[PIPE-2]) begin
            for (int k = 0; k < 16; k++) y_d[k] = rnd_sat(acc_src[k]);
        end
    end

    always_comb begin : pack_out
        y_pack = '0;
        for (int k = 0; k < 16; k++) y_pack[k*OUT_W +: OUT_W] = y_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '{default: 1'b0};
            size_q <= '{default: 2'd0};
            prod_q <= '{default: '{default: '0}};
            y_q    <= '{default: '0};
        end else begin
            v_q    <= v_d;
            size_q <= size_d;
            prod_q <= prod_d;
            y_q    <= y_d;
        end
    end
endmodule

// File: tb/tb_dct_odd_stage_cfg.sv
// Scoreboard bench: two stages (SHIFT=0 and SHIFT=7) driven in lockstep,
// expectations from a matrix-product reference model.
module tb_dct_odd_stage_cfg;
    localparam int IN_W  = 20;
    localparam int OUT_W = 20;
    localparam int PIPE  = 5;
    localparam int YW    = 16 * OUT_W;
    localparam int BW    = 16 * IN_W;

    localparam int MAG [33] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67,
                                64, 61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_odd_stage_cfg_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if0 ();
    dct_odd_stage_cfg_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if7 ();

    dct_odd_stage_cfg #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE(PIPE), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .io(if0.slave));
    dct_odd_stage_cfg #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE(PIPE), .SHIFT(7)) dut7 (
        .clk(clk), .rst(rst), .io(if7.slave));

    typedef struct {
        logic [YW-1:0] y0;
        logic [YW-1:0] y7;
        logic [1:0]    size;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   lat_next = 1'b0;
    int   sink_mode = 0;

    // C_32[r][j] from the cosine angle r*(2j+1) folded into the first quadrant
    function automatic longint c32(input int r, input int j);
        int n;
        n = (r * (2 * j + 1)) % 128;
        if (n <= 32) return longint'(MAG[n]);
        if (n <= 64) return -longint'(MAG[64 - n]);
        if (n <= 96) return -longint'(MAG[n - 64]);
        return longint'(MAG[128 - n]);
    endfunction

    function automatic logic [YW-1:0] model(input logic [1:0] size, input logic [BW-1:0] b, input int sh);
        logic [YW-1:0] y;
        longint acc;
        longint hi;
        int npt;
        npt = 4 << size;
        hi  = (64'sd1 <<< (OUT_W - 1)) - 1;
        y   = '0;
        for (int k = 0; k < npt / 2; k++) begin
            acc = 0;
            for (int j = 0; j < npt / 2; j++)
                acc += c32((2 * k + 1) * (32 / npt), j) * longint'($signed(b[j*IN_W +: IN_W]));
            if (sh > 0) acc = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
            if (acc > hi) acc = hi;
            if (acc < -hi - 1) acc = -hi - 1;
            y[k*OUT_W +: OUT_W] = acc[OUT_W-1:0];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [YW-1:0] got, input logic [YW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int j, input int v);
        logic [BW-1:0] r;
        r = b;
        r[j*IN_W +: IN_W] = IN_W'(v);
        return r;
    endfunction

    function automatic logic [BW-1:0] rbeat();
        logic [BW-1:0] b;
        bit big;
        big = ($urandom_range(0, 3) == 0);
        b = '0;
        for (int j = 0; j < 16; j++)
            b[j*IN_W +: IN_W] = big ? IN_W'($urandom) : IN_W'(int'($urandom_range(0, 8191)) - 4096);
        return b;
    endfunction

    task automatic drive(input bit v, input logic [1:0] size, input logic [BW-1:0] b);
        if0.in_valid = v;    if7.in_valid = v;
        if0.in_size  = size; if7.in_size  = size;
        if0.b_flat   = b;    if7.b_flat   = b;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [1:0] size, input logic [BW-1:0] b);
        int t;
        t = 0;
        drive(1'b1, size, b);
        @(negedge clk);
        while (!if0.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!if0.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        if0.out_ready = 1'b1;
        if7.out_ready = 1'b1;
        forever begin
            logic r;
            @(posedge clk);
            #2;
            case (sink_mode)
                1:       r = ($urandom_range(0, 99) < 70);
                2:       r = 1'b0;
                default: r = 1'b1;
            endcase
            if0.out_ready = r;
            if7.out_ready = r;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            chk("in_ready_rule", YW'(if0.in_ready), YW'(!(if0.out_valid && !if0.out_ready)));
            if (if0.out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_beat: got out_valid=1 expected 0 with no beat outstanding (cycle %0d)", cyc);
                end else begin
                    e = sb[0];
                    chk("y_shift0", if0.y_flat, e.y0);
                    chk("y_shift7", if7.y_flat, e.y7);
                    chk("out_size", YW'(if0.out_size), YW'(e.size));
                    chk("valid_shift7", YW'(if7.out_valid), YW'(1));
                    if (if0.out_ready) begin
                        if (e.chk_lat) chk("latency", YW'(cyc - e.acc_cyc), YW'(PIPE));
                        void'(sb.pop_front());
                    end
                end
            end
            if (if0.in_valid && if0.in_ready) begin
                e.y0      = model(if0.in_size, if0.b_flat, 0);
                e.y7      = model(if0.in_size, if0.b_flat, 7);
                e.size    = if0.in_size;
                e.acc_cyc = cyc;
                e.chk_lat = lat_next;
                lat_next  = 1'b0;
                sb.push_back(e);
            end
        end
    end

    initial begin
        logic [BW-1:0] b;
        drive(1'b0, 2'd0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", YW'(if0.out_valid), YW'(0));
        chk("rst_y_flat", if0.y_flat, YW'(0));
        chk("rst_y_flat7", if7.y_flat, YW'(0));
        chk("rst_out_size", YW'(if0.out_size), YW'(0));
        chk("rst_in_ready", YW'(if0.in_ready), YW'(1));
        @(posedge clk);
        #1;

        // impulses: 32pt with latency check, then 4pt/8pt with junk in ignored lanes
        lat_next = 1'b1;
        send(2'd3, put('0, 0, 1));
        drain();
        b = rbeat(); b = put(b, 0, 1); b = put(b, 1, 0);
        send(2'd0, b);
        b = rbeat(); b = put(b, 0, 0); b = put(b, 1, 1);
        send(2'd0, b);
        b = rbeat(); for (int j = 0; j < 4; j++) b = put(b, j, (j == 0) ? 1 : 0);
        send(2'd1, b);
        send(2'd3, put('0, 0, -1));
        drain();

        // mixed sizes back to back
        send(2'd3, rbeat());
        send(2'd0, rbeat());
        send(2'd2, rbeat());
        send(2'd1, rbeat());
        drain();

        // saturation at both rails
        b = '0; for (int j = 0; j < 16; j++) b = put(b, j, 524287);
        send(2'd3, b);
        b = '0; for (int j = 0; j < 16; j++) b = put(b, j, -524288);
        send(2'd3, b);
        drain();

        // backpressure with the pipe full
        for (int i = 0; i < PIPE; i++) send(2'($urandom_range(0, 3)), rbeat());
        sink_mode = 2;
        b = rbeat();
        drive(1'b1, 2'd2, b);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", YW'(if0.in_ready), YW'(0));
            chk("bp_out_valid", YW'(if0.out_valid), YW'(1));
            @(posedge clk);
            #1;
        end
        sink_mode = 0;
        send(2'd2, b);
        send(2'd1, rbeat());
        drain();

        // randomized traffic with random downstream readiness
        sink_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) send(2'($urandom_range(0, 3)), rbeat());
            else begin
                @(posedge clk);
                #1;
            end
        end
        sink_mode = 0;
        drain();

        // reset with three beats in flight
        send(2'd3, rbeat());
        send(2'd1, rbeat());
        send(2'd0, rbeat());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", YW'(if0.out_valid), YW'(0));
        chk("midrst_y_flat", if0.y_flat, YW'(0));
        chk("midrst_out_size", YW'(if0.out_size), YW'(0));
        repeat (8) @(posedge clk);
        #1;
        lat_next = 1'b1;
        send(2'd2, rbeat());
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
